fake_psx_controller: RTL and testbench

FAKE_PSX_CONTROLLER -- requirements
Module: fake_psx_controller

---
 rtl/fake_psx_controller.sv | 212 +++++++++++++++++++++
 tb/tb_fake_psx_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fake_psx_controller.sv
// Emulates a PSX digital pad: 5-byte poll, LSB-first serial, active-low ack pulses.
// Latency: 3 clk from pin edge to output change; the console paces transfers and no backpressure is applied.
module fake_psx_controller #(
    parameter int ACK_DELAY = 4,
    parameter int ACK_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic        att,
    input  logic [15:0] buttons,
    output logic        data,
    output logic        ack,
    output logic [7:0]  rx_byte,
    output logic        busy,
    output logic        poll_done
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_PULSE,
        DONE,
        IGNORE
    } state_t;

    logic att_s1_q, att_s2_q, att_dly_q;
    logic pclk_s1_q, pclk_s2_q, pclk_dly_q;
    logic cmd_s1_q, cmd_s2_q;

    state_t      state_q, state_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [15:0] btn_q, btn_d;
    logic        data_q, data_d;
    logic        ack_q, ack_d;
    logic        poll_done_q, poll_done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       att_fall, att_rise, pclk_rise, pclk_fall;
    logic [7:0] reply_first, reply_cur, reply_nxt, rx_full;
    logic       bad_byte;

    function automatic logic [7:0] reply_byte(input logic [2:0] idx, input logic [15:0] btn);
        case (idx)
            3'd0:    reply_byte = 8'hFF;
            3'd1:    reply_byte = 8'h41;
            3'd2:    reply_byte = 8'h5A;
            3'd3:    reply_byte = btn[7:0];
            3'd4:    reply_byte = btn[15:8];
            default: reply_byte = 8'hFF;
        endcase
    endfunction

    // Idle-high presets keep reset release from looking like an att or psx_clk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            att_s1_q   <= 1'b1;
            att_s2_q   <= 1'b1;
            att_dly_q  <= 1'b1;
            pclk_s1_q  <= 1'b1;
            pclk_s2_q  <= 1'b1;
            pclk_dly_q <= 1'b1;
            cmd_s1_q   <= 1'b1;
            cmd_s2_q   <= 1'b1;
        end else begin
            att_s1_q   <= att;
            att_s2_q   <= att_s1_q;
            att_dly_q  <= att_s2_q;
            pclk_s1_q  <= psx_clk;
            pclk_s2_q  <= pclk_s1_q;
            pclk_dly_q <= pclk_s2_q;
            cmd_s1_q   <= cmd;
            cmd_s2_q   <= cmd_s1_q;
        end
    end

    assign att_fall  = !att_s2_q &&  att_dly_q;
    assign att_rise  =  att_s2_q && !att_dly_q;
    assign pclk_rise =  pclk_s2_q && !pclk_dly_q;
    assign pclk_fall = !pclk_s2_q &&  pclk_dly_q;

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        btn_d       = btn_q;
        data_d      = data_q;
        ack_d       = ack_q;
        poll_done_d = 1'b0;
        cnt_d       = cnt_q;

        reply_first = reply_byte(3'd0, buttons);
        reply_cur   = reply_byte(byte_idx_q, btn_q);
        reply_nxt   = reply_byte(byte_idx_q + 3'd1, btn_q);
        rx_full     = {cmd_s2_q, shift_q};
        bad_byte    = ((byte_idx_q == 3'd0) && (rx_full != 8'h01)) ||
                      ((byte_idx_q == 3'd1) && (rx_full != 8'h42));

        if (att_rise) begin
            state_d = IDLE;
            data_d  = 1'b1;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (att_fall) begin
                        btn_d      = buttons;
                        byte_idx_d = 3'd0;
                        bit_cnt_d  = 3'd0;
                        data_d     = reply_first[0];
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    if (pclk_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            rx_byte_d = rx_full;
                            bit_cnt_d = 3'd0;
                            cnt_d     = '0;
                            if (bad_byte) begin
                                data_d  = 1'b1;
                                state_d = IGNORE;
                            end else if (byte_idx_q == 3'd4) begin
                                data_d      = 1'b1;
                                poll_done_d = 1'b1;
                                state_d     = DONE;
                            end else begin
                                state_d = ACK_WAIT;
                            end
                        end else begin
                            shift_d[bit_cnt_q] = cmd_s2_q;
                            bit_cnt_d          = bit_cnt_q + 3'd1;
                        end
                    end else if (pclk_fall && (bit_cnt_q != 3'd0)) begin
                        data_d = reply_cur[bit_cnt_q];
                    end
                end
                ACK_WAIT: begin
                    if (cnt_q == CW'(ACK_DELAY - 1)) begin
                        cnt_d      = '0;
                        ack_d      = 1'b0;
                        byte_idx_d = byte_idx_q + 3'd1;
                        data_d     = reply_nxt[0];
                        state_d    = ACK_PULSE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ACK_PULSE: begin
                    if (cnt_q == CW'(ACK_WIDTH - 1)) begin
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DONE, IGNORE: begin
                    data_d = 1'b1;
                    ack_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    data_d  = 1'b1;
                    ack_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_idx_q  <= 3'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rx_byte_q   <= 8'h00;
            btn_q       <= 16'hFFFF;
            data_q      <= 1'b1;
            ack_q       <= 1'b1;
            poll_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            btn_q       <= btn_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            poll_done_q <= poll_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign data      = data_q;
    assign ack       = ack_q;
    assign rx_byte   = rx_byte_q;
    assign busy      = (state_q != IDLE);
    assign poll_done = poll_done_q;

endmodule

// File: tb/tb_fake_psx_controller.sv
// Directed bench: console model drives polls, checks reply bytes, ack timing, aborts and reset.
module tb_fake_psx_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        psx_clk;
    logic        cmd;
    logic        att;
    logic [15:0] buttons;
    logic        data;
    logic        ack;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        poll_done;

    int checks = 0;
    int errors = 0;
    int pd_cnt = 0;

    fake_psx_controller #(.ACK_DELAY(4), .ACK_WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .psx_clk   (psx_clk),
        .cmd       (cmd),
        .att       (att),
        .buttons   (buttons),
        .data      (data),
        .ack       (ack),
        .rx_byte   (rx_byte),
        .busy      (busy),
        .poll_done (poll_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (poll_done === 1'b1) pd_cnt++;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: no ack expected, lat = ack-low samples seen in a window
    // mode 1: measure ack latency (from 8th rising pin edge) and width
    // mode 2: return as soon as ack is seen low
    task automatic xfer_byte(input logic [7:0] c, input int nbits, input int mode,
                             output logic [7:0] d, output int lat, output int w);
        d = 8'h00;
        lat = 0;
        w = 0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            cmd = c[i];
            psx_clk = 1'b0;
            repeat (8) @(negedge clk);
            psx_clk = 1'b1;
            d[i] = data;
        end
        if (nbits == 8) begin
            if (mode == 0) begin
                repeat (16) begin
                    @(negedge clk);
                    if (ack !== 1'b1) lat++;
                end
            end else begin
                do begin
                    @(negedge clk);
                    lat++;
                end while (ack !== 1'b0 && lat < 40);
                if (mode == 1) begin
                    while (ack === 1'b0 && w < 40) begin
                        w++;
                        @(negedge clk);
                    end
                end
            end
        end
    endtask

    task automatic full_poll(input logic [15:0] btn, input bit change_btn);
        logic [7:0] cmds [5];
        logic [7:0] exp_d [5];
        logic [7:0] d;
        int lat, w, pd0;
        cmds  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
        exp_d = '{8'hFF, 8'h41, 8'h5A, btn[7:0], btn[15:8]};
        buttons = btn;
        pd0 = pd_cnt;
        @(negedge clk);
        att = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_lat_early", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("busy_lat", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            if (change_btn && b == 2) buttons = 16'h0000;
            xfer_byte(cmds[b], 8, (b < 4) ? 1 : 0, d, lat, w);
            chk($sformatf("poll_data%0d", b), {24'd0, d}, {24'd0, exp_d[b]});
            if (b < 4) begin
                chk($sformatf("ack_lat%0d", b), lat, 32'd7);
                chk($sformatf("ack_width%0d", b), w, 32'd8);
            end else begin
                chk("byte4_noack", lat, 32'd0);
            end
        end
        chk("poll_done_once", pd_cnt - pd0, 32'd1);
        chk("rx_byte_end", {24'd0, rx_byte}, 32'h00);
        chk("data_done", {31'd0, data}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd1);
        att = 1'b1;
        repeat (3) @(negedge clk);
        chk("busy_after_att", {31'd0, busy}, 32'd0);
        buttons = 16'hFFFE;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        int lat, w, pd0;
        reset = 1'b1;
        psx_clk = 1'b1;
        cmd = 1'b1;
        att = 1'b1;
        buttons = 16'hFFFE;
        repeat (3) @(negedge clk);
        chk("rst_data", {31'd0, data}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd1);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_poll_done", {31'd0, poll_done}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        full_poll(16'hFFFE, 1'b0);
        full_poll(16'hFFFE, 1'b1);
        full_poll(16'h3CA5, 1'b0);

        // bad first command byte: ignored until att rises
        att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h81, 8, 0, d, lat, w);
        chk("ign_data0", {24'd0, d}, 32'hFF);
        chk("ign_noack0", lat, 32'd0);
        xfer_byte(8'h42, 8, 0, d, lat, w);
        chk("ign_data1", {24'd0, d}, 32'hFF);
        chk("ign_noack1", lat, 32'd0);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        att = 1'b1;
        repeat (3) @(negedge clk);
        chk("ign_busy_end", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        // abort after 3 bits of byte 2
        pd0 = pd_cnt;
        att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h01, 8, 1, d, lat, w);
        xfer_byte(8'h42, 8, 1, d, lat, w);
        chk("abort_pre_data1", {24'd0, d}, 32'h41);
        xfer_byte(8'h00, 3, 1, d, lat, w);
        @(negedge clk);
        att = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy_early", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_data", {31'd0, data}, 32'd1);
        chk("abort_ack", {31'd0, ack}, 32'd1);
        chk("abort_no_pd", pd_cnt - pd0, 32'd0);
        repeat (4) @(negedge clk);

        // reset during the ack pulse, then a normal poll
        att = 1'b0;
        repeat (6) @(negedge clk);
        xfer_byte(8'h01, 8, 2, d, lat, w);
        chk("rstack_lat", lat, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        att = 1'b1;
        @(negedge clk);
        chk("rstack_ack", {31'd0, ack}, 32'd1);
        chk("rstack_data", {31'd0, data}, 32'd1);
        chk("rstack_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        full_poll(16'hFFFE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
